// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, key expanded on the fly. Result valid 10 cycles
// after accept. The ciphertext is held stable while out_ready is low, and no new block is taken until it drains.
module aes128_enc_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic [3:0]   round
);

   // Forward S-box, entry 0 in the most-significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t         fsm, fsm_nxt;
   logic [127:0] state_reg, rk_reg, rk_next, sr_out, mc_out, round_out;
   logic [31:0]  kx_t, nw0, nw1, nw2, nw3;
   logic [7:0]   rcon;
   logic [3:0]   round_reg;
   logic         last_round;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] inv;
      inv = ~b;
      return SBOX_TBL[{inv, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[7:0];
      a1 = col[15:8];
      a2 = col[23:16];
      a3 = col[31:24];
      mix_col[7:0]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mix_col[15:8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mix_col[23:16] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mix_col[31:24] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   endfunction

   assign last_round = (round_reg == 4'd10);

   // Next round key; RotWord moves the low byte of w3 to the top.
   always_comb begin
      kx_t    = sub_word({rk_reg[103:96], rk_reg[127:104]}) ^ {24'b0, rcon};
      nw0     = rk_reg[31:0] ^ kx_t;
      nw1     = rk_reg[63:32] ^ nw0;
      nw2     = rk_reg[95:64] ^ nw1;
      nw3     = rk_reg[127:96] ^ nw2;
      rk_next = {nw3, nw2, nw1, nw0};
   end

   always_comb begin
      sr_out = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_out[c*32 + r*8 +: 8] = sbox(state_reg[((c + r) % 4)*32 + r*8 +: 8]);
         end
      end
   end

   always_comb begin
      mc_out = '0;
      for (int c = 0; c < 4; c++) begin
         mc_out[c*32 +: 32] = mix_col(sr_out[c*32 +: 32]);
      end
   end

   assign round_out = (last_round ? sr_out : mc_out) ^ rk_next;

   always_ff @(posedge clk) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         IDLE:    if (in_valid)   fsm_nxt = RUN;
         RUN:     if (last_round) fsm_nxt = DONE;
         DONE:    if (out_ready)  fsm_nxt = IDLE;
         default: fsm_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (fsm)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= '0;
         rk_reg    <= '0;
         rcon      <= 8'h01;
         round_reg <= 4'd0;
      end else begin
         case (fsm)
            IDLE: if (in_valid) begin
               state_reg <= plaintext ^ key;
               rk_reg    <= key;
               rcon      <= 8'h01;
               round_reg <= 4'd1;
            end
            RUN: begin
               state_reg <= round_out;
               rk_reg    <= rk_next;
               rcon      <= xtime(rcon);
               if (!last_round) round_reg <= round_reg + 4'd1;
            end
            DONE: if (out_ready) round_reg <= 4'd0;
            default: ;
         endcase
      end
   end

   assign ciphertext = state_reg;
   assign round      = round_reg;

endmodule
